// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch front end. It walks a fetch PC through instruction
//   memory with at most one read in flight, and buffers returned words in a
//   small FIFO that presents its head entry to IF/ID. Branch redirects flush
//   the buffer. A response to a request that was overtaken by a redirect is
//   dropped.
//
//   Optional feature macro: FETCH_BUF2_EN
//     defined   -> 2-entry buffer, so fetching continues through a one-cycle
//                  stall
//     undefined -> 1-entry buffer (default build)
//
//   Ports
//     clk_i            clock, all state changes on its rising edge
//     rst_i            synchronous active-high reset
//     stall_i          1 = IF/ID not accepting; the head entry is held
//     branch_i         single-cycle redirect request
//     branch_target_i  redirect byte address (low two bits ignored)
//     imem_req_o       one-cycle read request pulse
//     imem_addr_o      read address, valid with imem_req_o
//     imem_valid_i     read data return strobe (latency >= 1 cycle)
//     imem_data_i      returned instruction word
//     valid_o          head entry holds a real instruction
//     pc_o             byte address of the head instruction
//     instruction_o    head instruction word
// ----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_data_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instruction_o
);

`ifdef FETCH_BUF2_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state_reg;
  logic [31:0] fetch_pc_reg;
  logic [1:0]  count_reg;
  // Buffer slots: head is the entry presented downstream, tail is only
  // ever written in the 2-entry build.
  logic [31:0] head_pc_reg;
  logic [31:0] head_instr_reg;
  logic [31:0] tail_pc_reg;
  logic [31:0] tail_instr_reg;

  logic        has_entry;
  logic        pop;
  logic        slot_free;
  logic        push;
  logic        req_idle;
  logic        req_wait;
  logic [1:0]  count_next;
  logic [1:0]  wr_idx;
  logic [31:0] pc_plus4;

  // Redirect targets are word aligned; the low bits are dropped.
  logic unused_target_bits;
  assign unused_target_bits = ^branch_target_i[1:0];

  always_comb begin
    has_entry  = (count_reg != 2'd0);
    pop        = has_entry && !stall_i;
    // A slot freed by this cycle's pop can be claimed by a new request.
    slot_free  = (count_reg < DEPTH) || pop;
    // A request is only issued while a slot is reserved for it, so a
    // response never lands on a full buffer unless a pop frees a slot.
    push       = (state_reg == S_WAIT) && imem_valid_i && !branch_i;
    wr_idx     = count_reg - {1'b0, pop};
    count_next = count_reg + {1'b0, push} - {1'b0, pop};
    // Natural 32-bit overflow gives the FFFF_FFFC -> 0000_0000 wrap.
    pc_plus4   = fetch_pc_reg + 32'd4;
    req_idle   = (state_reg == S_IDLE) && slot_free && !branch_i;
    // Back-to-back request from WAIT when the pushed word leaves room.
    req_wait   = push && (count_next < DEPTH);
  end

  // The request is decoded from registered state so that it can go out in
  // the same cycle a slot frees up (and in the first cycle after reset).
  assign imem_req_o    = !rst_i && (req_idle || req_wait);
  assign imem_addr_o   = req_wait ? pc_plus4 : fetch_pc_reg;
  assign valid_o       = !rst_i && has_entry;
  assign pc_o          = rst_i ? 32'd0 : head_pc_reg;
  assign instruction_o = rst_i ? 32'd0 : head_instr_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= S_IDLE;
      fetch_pc_reg   <= RESET_PC;
      count_reg      <= 2'd0;
      head_pc_reg    <= 32'd0;
      head_instr_reg <= 32'd0;
      tail_pc_reg    <= 32'd0;
      tail_instr_reg <= 32'd0;
    end else if (branch_i) begin
      // Redirect wins over stall and over any returning word.
      count_reg    <= 2'd0;
      fetch_pc_reg <= {branch_target_i[31:2], 2'b00};
      case (state_reg)
        // Outstanding read not yet back: remember to drop it.
        S_WAIT:  state_reg <= imem_valid_i ? S_IDLE : S_DISCARD;
        default: state_reg <= state_reg;
      endcase
    end else begin
      count_reg <= count_next;
      if (push) begin
        fetch_pc_reg <= pc_plus4;
      end

      if (push && (wr_idx == 2'd0)) begin
        head_pc_reg    <= fetch_pc_reg;
        head_instr_reg <= imem_data_i;
      end else if (pop) begin
        head_pc_reg    <= tail_pc_reg;
        head_instr_reg <= tail_instr_reg;
      end

      if ((DEPTH == 2'd2) && push && (wr_idx == 2'd1)) begin
        tail_pc_reg    <= fetch_pc_reg;
        tail_instr_reg <= imem_data_i;
      end

      case (state_reg)
        S_IDLE: begin
          // Responses seen here belong to requests killed by reset.
          if (req_idle) begin
            state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_valid_i) begin
            state_reg <= req_wait ? S_WAIT : S_IDLE;
          end
        end
        S_DISCARD: begin
          if (imem_valid_i) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] MAGIC = 32'hA5C3_0F17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, branch, mem_valid;
  logic [31:0] target, mem_data;
  logic        req1, v1, req2, v2;
  logic [31:0] addr1, pc1, ins1, addr2, pc2, ins2;

  int checks = 0;
  int errors = 0;

  // Memory model state
  bit          pending;
  logic [31:0] pend_addr, resp_addr;
  int          pend_left, latency, proto_viol, cyc;

  // Per-cycle samples and popped-entry log
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr, s2_addr;
  logic [31:0] pop_pc[$], pop_instr[$], pop2_pc[$];
  int          pop_cyc[$];

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .branch_i(branch),
    .branch_target_i(target), .imem_req_o(req1), .imem_addr_o(addr1),
    .imem_valid_i(mem_valid), .imem_data_i(mem_data),
    .valid_o(v1), .pc_o(pc1), .instruction_o(ins1)
  );

  // Same stimulus, different reset PC: its PCs run 4 bytes behind dut.
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .branch_i(branch),
    .branch_target_i(target), .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_valid_i(mem_valid), .imem_data_i(mem_data),
    .valid_o(v2), .pc_o(pc2), .instruction_o(ins2)
  );

  // Sample the current cycle (inputs already set), then advance one clock
  // and drive the memory response for the new cycle.
  task automatic step();
    #1;
    s_req = req1; s_addr = addr1; s_valid = v1; s_pc = pc1; s_instr = ins1;
    s2_addr = addr2;
    if (s_req) begin
      if (pending) proto_viol++;
      pending = 1'b1; pend_addr = s_addr; pend_left = latency;
    end
    if (!rst && s_valid && !stall && !branch) begin
      pop_pc.push_back(s_pc); pop_instr.push_back(s_instr);
      pop2_pc.push_back(pc2); pop_cyc.push_back(cyc);
    end
    @(negedge clk);
    cyc++;
    mem_valid = 1'b0; mem_data = 32'd0;
    if (pending) begin
      pend_left--;
      if (pend_left <= 0) begin
        mem_valid = 1'b1; mem_data = pend_addr ^ MAGIC;
        resp_addr = pend_addr; pending = 1'b0;
      end
    end
  endtask

  task automatic clear_log();
    pop_pc.delete(); pop_instr.delete(); pop2_pc.delete(); pop_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; branch = 1'b0;
    step(); step();
    pending = 1'b0; mem_valid = 1'b0; mem_data = 32'd0;
    clear_log();
    rst = 1'b0;
  endtask

  task automatic run_pops(input int n, input int budget);
    int k = 0;
    while (pop_pc.size() < n && k < budget) begin
      step(); k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b1; branch = 1'b1; target = 32'h0000_0500;
    step(); step();
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", s_valid); end
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%0h exp=0", s_req); end
    checks++; if (s_pc !== 32'd0) begin errors++; $display("FAIL reset_pc got=%h exp=0", s_pc); end
    checks++; if (s_instr !== 32'd0) begin errors++; $display("FAIL reset_instr got=%h exp=0", s_instr); end
    rst = 1'b0; stall = 1'b0; branch = 1'b0;
    step();
    checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL first_req got=%0h exp=1", s_req); end
    checks++; if (s_addr !== 32'd0) begin errors++; $display("FAIL first_addr got=%h exp=0", s_addr); end
    checks++; if (s2_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL first_addr_wrap got=%h exp=fffffffc", s2_addr); end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_sequential();
    int base;
    logic [31:0] e_pc, e_pc2;
    latency = 1;
    do_reset();
    base = cyc;
    run_pops(6, 40);
    checks++; if (pop_pc.size() != 6) begin errors++; $display("FAIL seq_count got=%0d exp=6", pop_pc.size()); end
    for (int i = 0; i < 6 && i < pop_pc.size(); i++) begin
      e_pc = 32'(i * 4);
      e_pc2 = e_pc - 32'd4;
      checks++; if (pop_pc[i] !== e_pc) begin errors++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pop_pc[i], e_pc); end
      checks++; if (pop_instr[i] !== (e_pc ^ MAGIC)) begin errors++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, pop_instr[i], e_pc ^ MAGIC); end
      checks++; if (pop2_pc[i] !== e_pc2) begin errors++; $display("FAIL wrap_pc[%0d] got=%h exp=%h", i, pop2_pc[i], e_pc2); end
    end
    if (pop_cyc.size() == 6) begin
      checks++; if (pop_cyc[0] - base != 2) begin errors++; $display("FAIL seq_first_latency got=%0d exp=2", pop_cyc[0] - base); end
`ifdef FETCH_BUF2_EN
      checks++; if (pop_cyc[5] - pop_cyc[0] != 5) begin errors++; $display("FAIL seq_span got=%0d exp=5", pop_cyc[5] - pop_cyc[0]); end
`else
      checks++; if (pop_cyc[5] - pop_cyc[0] != 10) begin errors++; $display("FAIL seq_span got=%0d exp=10", pop_cyc[5] - pop_cyc[0]); end
`endif
    end
    $display("test_sequential done: pops=%0d errors=%0d", pop_pc.size(), errors);
  endtask

  task automatic test_stall();
    bit found = 1'b0;
    latency = 1;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      #1;
      if (v1 === 1'b1 && pc1 === 32'd8) begin found = 1'b1; break; end
      step();
    end
    checks++; if (!found) begin errors++; $display("FAIL stall_reach_pc8 got=timeout exp=pc 8"); end
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got=%0h exp=1", k, s_valid); end
      checks++; if (s_pc !== 32'd8) begin errors++; $display("FAIL stall_pc[%0d] got=%h exp=8", k, s_pc); end
      checks++; if (s_instr !== (32'd8 ^ MAGIC)) begin errors++; $display("FAIL stall_instr[%0d] got=%h exp=%h", k, s_instr, 32'd8 ^ MAGIC); end
    end
    stall = 1'b0;
    clear_log();
    run_pops(3, 20);
    checks++; if (pop_pc.size() != 3) begin errors++; $display("FAIL stall_count got=%0d exp=3", pop_pc.size()); end
    for (int i = 0; i < 3 && i < pop_pc.size(); i++) begin
      checks++; if (pop_pc[i] !== 32'(8 + 4 * i)) begin errors++; $display("FAIL stall_seq[%0d] got=%h exp=%h", i, pop_pc[i], 32'(8 + 4 * i)); end
    end
    if (pop_cyc.size() >= 2) begin
`ifdef FETCH_BUF2_EN
      checks++; if (pop_cyc[1] - pop_cyc[0] != 1) begin errors++; $display("FAIL stall_release_gap got=%0d exp=1", pop_cyc[1] - pop_cyc[0]); end
`else
      checks++; if (pop_cyc[1] - pop_cyc[0] != 2) begin errors++; $display("FAIL stall_release_gap got=%0d exp=2", pop_cyc[1] - pop_cyc[0]); end
`endif
    end
    $display("test_stall done: errors=%0d", errors);
  endtask

  task automatic test_branch_idle();
    latency = 1;
    do_reset();
    stall = 1'b1;
    repeat (6) step();
    branch = 1'b1; target = 32'h0000_0203;
    step();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL bidle_req_in_branch got=%0h exp=0", s_req); end
    branch = 1'b0; stall = 1'b0;
    step();
    checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL bidle_req got=%0h exp=1", s_req); end
    checks++; if (s_addr !== 32'h0000_0200) begin errors++; $display("FAIL bidle_addr got=%h exp=00000200", s_addr); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL bidle_flush got=%0h exp=0", s_valid); end
    step();
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL bidle_bubble got=%0h exp=0", s_valid); end
    step();
    checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL bidle_valid got=%0h exp=1", s_valid); end
    checks++; if (s_pc !== 32'h0000_0200) begin errors++; $display("FAIL bidle_pc got=%h exp=00000200", s_pc); end
    checks++; if (s_instr !== (32'h200 ^ MAGIC)) begin errors++; $display("FAIL bidle_instr got=%h exp=%h", s_instr, 32'h200 ^ MAGIC); end
    $display("test_branch_idle done: errors=%0d", errors);
  endtask

  task automatic test_branch_discard();
    bit got_req = 1'b0;
    logic [31:0] first_addr = 32'd0;
    latency = 3;
    do_reset();
    step();
    branch = 1'b1; target = 32'h0000_0103;
    step();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL bdisc_req_in_branch got=%0h exp=0", s_req); end
    branch = 1'b0;
    clear_log();
    for (int k = 0; k < 40 && pop_pc.size() < 2; k++) begin
      step();
      if (s_req && !got_req) begin got_req = 1'b1; first_addr = s_addr; end
    end
    checks++; if (!got_req) begin errors++; $display("FAIL bdisc_req got=timeout exp=request"); end
    checks++; if (first_addr !== 32'h0000_0100) begin errors++; $display("FAIL bdisc_addr got=%h exp=00000100", first_addr); end
    checks++; if (pop_pc.size() != 2) begin errors++; $display("FAIL bdisc_count got=%0d exp=2", pop_pc.size()); end
    if (pop_pc.size() == 2) begin
      checks++; if (pop_pc[0] !== 32'h100) begin errors++; $display("FAIL bdisc_pc0 got=%h exp=00000100", pop_pc[0]); end
      checks++; if (pop_instr[0] !== (32'h100 ^ MAGIC)) begin errors++; $display("FAIL bdisc_instr0 got=%h exp=%h", pop_instr[0], 32'h100 ^ MAGIC); end
      checks++; if (pop_pc[1] !== 32'h104) begin errors++; $display("FAIL bdisc_pc1 got=%h exp=00000104", pop_pc[1]); end
    end
    $display("test_branch_discard done: errors=%0d", errors);
  endtask

  task automatic test_branch_collide();
    bit found = 1'b0;
    logic [31:0] collide_addr;
`ifdef FETCH_BUF2_EN
    collide_addr = 32'd4;
`else
    collide_addr = 32'd0;
`endif
    latency = 2;
    do_reset();
    stall = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (mem_valid === 1'b1 && resp_addr === collide_addr) begin found = 1'b1; break; end
      step();
    end
    checks++; if (!found) begin errors++; $display("FAIL bcol_setup got=timeout exp=response"); end
    branch = 1'b1; target = 32'h0000_0040;
    step();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL bcol_req_in_branch got=%0h exp=0", s_req); end
    branch = 1'b0;
    step();
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL bcol_flush got=%0h exp=0", s_valid); end
    stall = 1'b0;
    clear_log();
    run_pops(1, 20);
    checks++; if (pop_pc.size() < 1 || pop_pc[0] !== 32'h40) begin errors++; $display("FAIL bcol_next_pc got=%h exp=00000040", (pop_pc.size() > 0) ? pop_pc[0] : 32'hxxxx_xxxx); end
    $display("test_branch_collide done: errors=%0d", errors);
  endtask

  task automatic test_reset_mid_wait();
    latency = 1;
    do_reset();
    stall = 1'b1;
    repeat (6) step();
    branch = 1'b1; target = 32'h0000_0300;
    step();
    branch = 1'b0; stall = 1'b0; latency = 3;
    step();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h300) begin errors++; $display("FAIL rmw_setup got=%0h/%h exp=1/00000300", s_req, s_addr); end
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    clear_log();
    step();
    checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL rmw_req got=%0h exp=1", s_req); end
    checks++; if (s_addr !== 32'd0) begin errors++; $display("FAIL rmw_addr got=%h exp=00000000", s_addr); end
    run_pops(1, 20);
    checks++; if (pop_pc.size() < 1 || pop_pc[0] !== 32'd0) begin errors++; $display("FAIL rmw_pc got=%h exp=00000000", (pop_pc.size() > 0) ? pop_pc[0] : 32'hxxxx_xxxx); end
    checks++; if (pop_instr.size() < 1 || pop_instr[0] !== MAGIC) begin errors++; $display("FAIL rmw_instr got=%h exp=%h", (pop_instr.size() > 0) ? pop_instr[0] : 32'hxxxx_xxxx, MAGIC); end
    $display("test_reset_mid_wait done: errors=%0d", errors);
  endtask

  task automatic test_one_outstanding();
    checks++; if (proto_viol != 0) begin errors++; $display("FAIL one_outstanding got=%0d overlaps exp=0", proto_viol); end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch = 1'b0; target = 32'd0;
    mem_valid = 1'b0; mem_data = 32'd0;
    pending = 1'b0; pend_addr = 32'd0; resp_addr = 32'd0; pend_left = 0;
    latency = 1; proto_viol = 0; cyc = 0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_branch_idle();
    test_branch_discard();
    test_branch_collide();
    test_reset_mid_wait();
    test_one_outstanding();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
